// File: rtl/ts_precharge_ctrl.sv
// Tractive-system relay sequencer: AIR- close, precharge, AIR+ close, then ACTIVE.
// Optional PRECHARGE_MIN_TIME_EN enforces a minimum precharge dwell before AIR+ may close.
module ts_precharge_ctrl #(
  parameter logic [15:0] SETTLE_CYCLES        = 16'd100,
  parameter logic [6:0]  PRECHARGE_PCT        = 7'd90,
  parameter logic [11:0] ACC_MIN              = 12'd100,
  parameter logic [15:0] TIMEOUT_CYCLES       = 16'd5000,
  parameter logic [15:0] OVERLAP_CYCLES       = 16'd50,
  parameter logic [15:0] MIN_PRECHARGE_CYCLES = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SDC_final,
  input  logic        ts_request,
  input  logic [11:0] acc_voltage,
  input  logic [11:0] bus_voltage,
  input  logic        fault_clear,
  output logic        air_neg,
  output logic        air_pos,
  output logic        precharge_relay,
  output logic        ts_active,
  output logic        precharge_fault
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLOSE_NEG = 3'd1,
    PRECHARGE = 3'd2,
    CLOSE_POS = 3'd3,
    ACTIVE    = 3'd4,
    FAULT     = 3'd5
  } state_t;

  // A zero cycle count behaves as one, so the terminal count never underflows.
  localparam logic [15:0] SETTLE_LAST  = (SETTLE_CYCLES  == 16'd0) ? 16'd0 : SETTLE_CYCLES  - 16'd1;
  localparam logic [15:0] OVERLAP_LAST = (OVERLAP_CYCLES == 16'd0) ? 16'd0 : OVERLAP_CYCLES - 16'd1;
  localparam logic [15:0] TIMEOUT_LAST = (TIMEOUT_CYCLES == 16'd0) ? 16'd0 : TIMEOUT_CYCLES - 16'd1;
  localparam logic [15:0] MIN_LAST     = (MIN_PRECHARGE_CYCLES == 16'd0) ? 16'd0 :
                                         MIN_PRECHARGE_CYCLES - 16'd1;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_cnt;

  logic        r_air_neg;
  logic        r_air_pos;
  logic        r_precharge_relay;
  logic        r_ts_active;
  logic        r_precharge_fault;

  logic        w_air_neg;
  logic        w_air_pos;
  logic        w_precharge_relay;
  logic        w_ts_active;
  logic        w_precharge_fault;

  logic [18:0] w_bus_scaled;
  logic [18:0] w_acc_scaled;
  logic        w_cond;
  logic        w_min_ok;
  logic        w_abort;

  assign w_bus_scaled = {7'd0, bus_voltage} * 19'd100;
  assign w_acc_scaled = {7'd0, acc_voltage} * {12'd0, PRECHARGE_PCT};
  assign w_cond       = (acc_voltage >= ACC_MIN) && (w_bus_scaled >= w_acc_scaled);
  assign w_abort      = !SDC_final || !ts_request;

`ifdef PRECHARGE_MIN_TIME_EN
  assign w_min_ok = (r_cnt >= MIN_LAST);
`else
  assign w_min_ok = 1'b1 | (r_cnt >= MIN_LAST);
`endif

  // State, dwell counter and registered relay drives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= IDLE;
      r_cnt             <= 16'd0;
      r_air_neg         <= 1'b0;
      r_air_pos         <= 1'b0;
      r_precharge_relay <= 1'b0;
      r_ts_active       <= 1'b0;
      r_precharge_fault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_cnt <= 16'd0;
      end else if (r_cnt != 16'hFFFF) begin
        r_cnt <= r_cnt + 16'd1;
      end
      r_air_neg         <= w_air_neg;
      r_air_pos         <= w_air_pos;
      r_precharge_relay <= w_precharge_relay;
      r_ts_active       <= w_ts_active;
      r_precharge_fault <= w_precharge_fault;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (ts_request && SDC_final) w_state_next = CLOSE_NEG;
      end
      CLOSE_NEG: begin
        if (w_abort)                   w_state_next = IDLE;
        else if (r_cnt >= SETTLE_LAST) w_state_next = PRECHARGE;
      end
      PRECHARGE: begin
        // A met condition on the timeout cycle wins over the fault.
        if (w_abort)                                w_state_next = IDLE;
        else if (w_cond && w_min_ok)                w_state_next = CLOSE_POS;
        else if ((r_cnt >= TIMEOUT_LAST) && !w_cond) w_state_next = FAULT;
      end
      CLOSE_POS: begin
        if (w_abort)                    w_state_next = IDLE;
        else if (r_cnt >= OVERLAP_LAST) w_state_next = ACTIVE;
      end
      ACTIVE: begin
        if (w_abort) w_state_next = IDLE;
      end
      FAULT: begin
        if (fault_clear && !ts_request) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_air_neg         = 1'b0;
    w_air_pos         = 1'b0;
    w_precharge_relay = 1'b0;
    w_ts_active       = 1'b0;
    w_precharge_fault = 1'b0;
    unique case (r_state)
      CLOSE_NEG: w_air_neg = 1'b1;
      PRECHARGE: begin
        w_air_neg         = 1'b1;
        w_precharge_relay = 1'b1;
      end
      CLOSE_POS: begin
        w_air_neg         = 1'b1;
        w_precharge_relay = 1'b1;
        w_air_pos         = 1'b1;
      end
      ACTIVE: begin
        w_air_neg   = 1'b1;
        w_air_pos   = 1'b1;
        w_ts_active = 1'b1;
      end
      FAULT:   w_precharge_fault = 1'b1;
      default: w_air_neg = 1'b0;
    endcase
  end

  assign air_neg         = r_air_neg;
  assign air_pos         = r_air_pos;
  assign precharge_relay = r_precharge_relay;
  assign ts_active       = r_ts_active;
  assign precharge_fault = r_precharge_fault;

endmodule

// File: tb/tb_ts_precharge_ctrl.sv
// Directed bench for ts_precharge_ctrl with default parameters.
// Output vector order: {air_neg, precharge_relay, air_pos, ts_active, precharge_fault}.
module tb_ts_precharge_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SDC_final = 1'b0;
  logic        ts_request = 1'b0;
  logic [11:0] acc_voltage = 12'd2000;
  logic [11:0] bus_voltage = 12'd0;
  logic        fault_clear = 1'b0;
  logic        air_neg;
  logic        air_pos;
  logic        precharge_relay;
  logic        ts_active;
  logic        precharge_fault;

  logic [4:0]  outs;
  int          checks = 0;
  int          errors = 0;

  assign outs = {air_neg, precharge_relay, air_pos, ts_active, precharge_fault};

  ts_precharge_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .SDC_final       (SDC_final),
    .ts_request      (ts_request),
    .acc_voltage     (acc_voltage),
    .bus_voltage     (bus_voltage),
    .fault_clear     (fault_clear),
    .air_neg         (air_neg),
    .air_pos         (air_pos),
    .precharge_relay (precharge_relay),
    .ts_active       (ts_active),
    .precharge_fault (precharge_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
    $display("check %0d %s: outs=%b expected=%b", checks, tag, obs, exp);
  endtask

  // From IDLE, request TS-on and stop right after the edge that enters PRECHARGE.
  task automatic go_to_precharge();
    ts_request = 1'b1;
    SDC_final  = 1'b1;
    repeat (101) tick();
    check("pre_entry", outs, 5'b10000);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", outs, 5'b00000);
    rst = 1'b0;
    tick();
    check("idle_hold", outs, 5'b00000);

    // Nominal: acc=2000, bus ramps from 0; threshold is bus=1800.
    ts_request = 1'b1;
    SDC_final  = 1'b1;
    tick();
    check("neg_lag", outs, 5'b00000);
    tick();
    check("neg_on", outs, 5'b10000);
    repeat (99) tick();
    check("settle_end", outs, 5'b10000);
    for (int k = 0; k < 1800; k++) begin
      bus_voltage = 12'(k);
      tick();
      if (k == 0)    check("precharge_on", outs, 5'b11000);
      if (k == 1799) check("below_thresh", outs, 5'b11000);
    end
    bus_voltage = 12'd1800;
    tick();
    check("pos_lag", outs, 5'b11000);
    tick();
    check("pos_on", outs, 5'b11100);
    repeat (49) tick();
    check("overlap_end", outs, 5'b11100);
    tick();
    check("active", outs, 5'b10110);
    tick();
    check("active_hold", outs, 5'b10110);

    // Asynchronous reset while ACTIVE, sampled before the next clock edge.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", outs, 5'b00000);
    ts_request = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("post_reset", outs, 5'b00000);

    // Abort in CLOSE_POS: bus already charged so AIR+ closes immediately.
    bus_voltage = 12'd1800;
    go_to_precharge();
    tick();
    check("abort_pre", outs, 5'b11000);
    tick();
    check("abort_closepos", outs, 5'b11100);
    SDC_final = 1'b0;
    repeat (2) tick();
    check("abort_open", outs, 5'b00000);
    ts_request = 1'b0;
    SDC_final  = 1'b1;
    tick();
    check("abort_idle", outs, 5'b00000);

    // Timeout: bus stuck at 1000.
    bus_voltage = 12'd1000;
    go_to_precharge();
    repeat (4999) tick();
    check("to_before", outs, 5'b11000);
    tick();
    check("to_lag", outs, 5'b11000);
    tick();
    check("to_fault", outs, 5'b00001);
    fault_clear = 1'b1;
    SDC_final   = 1'b0;
    repeat (3) tick();
    check("fault_req_hold", outs, 5'b00001);
    ts_request = 1'b0;
    repeat (2) tick();
    check("fault_cleared", outs, 5'b00000);
    fault_clear = 1'b0;
    SDC_final   = 1'b1;

    // Invalid accumulator: ratio is met but acc is below ACC_MIN.
    acc_voltage = 12'd50;
    bus_voltage = 12'd50;
    go_to_precharge();
    repeat (5000) tick();
    check("inv_acc_hold", outs, 5'b11000);
    tick();
    check("inv_acc_fault", outs, 5'b00001);
    fault_clear = 1'b1;
    ts_request  = 1'b0;
    repeat (2) tick();
    check("inv_acc_clear", outs, 5'b00000);
    fault_clear = 1'b0;

    // Condition becomes true on the exact timeout cycle.
    acc_voltage = 12'd2000;
    bus_voltage = 12'd1000;
    go_to_precharge();
    repeat (4999) tick();
    check("simul_before", outs, 5'b11000);
    bus_voltage = 12'd1800;
    repeat (2) tick();
    check("simul_cond_wins", outs, 5'b11100);
    ts_request = 1'b0;
    repeat (2) tick();
    check("simul_release", outs, 5'b00000);

    // Timeout coincides with SDC loss.
    bus_voltage = 12'd1000;
    go_to_precharge();
    repeat (4999) tick();
    SDC_final = 1'b0;
    repeat (2) tick();
    check("simul_abort", outs, 5'b00000);
    tick();
    check("simul_abort_hold", outs, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
